// File: rtl/seq_detect_ctrl.sv
// Sequence-detector controller: captures a pattern configuration, shifts qualified serial
// bits into a history register, pulses z on each match and stops at a programmable count.
module seq_detect_ctrl #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             x,
    input  logic             x_valid,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StArmed, StDone} state_e;

    localparam logic [LEN_W-1:0] PatWLen = LEN_W'(PAT_W);

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   hist_q, pat_q, hist_new, mask;
    logic [LEN_W-1:0]   len_q, fill_q, fill_new, len_clamped;
    logic [CNT_W-1:0]   target_q, count_q, count_inc;
    logic               overlap_q, loaded_q, z_q, busy_q, done_q, cfg_ready_q;
    logic               cfg_fire, bit_fire, match, arm;

    always_comb begin
        cfg_fire  = cfg_valid && (state_q == StIdle);
        hist_new  = {hist_q[PAT_W-2:0], x};
        fill_new  = (fill_q == PatWLen) ? PatWLen : fill_q + LEN_W'(1);
        count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);

        mask = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            mask[i] = (i < int'(len_q));
        end
        match = (fill_new >= len_q) && (((hist_new ^ pat_q) & mask) == '0);

        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > PatWLen) begin
            len_clamped = PatWLen;
        end else begin
            len_clamped = cfg_len;
        end

        // abort beats start beats a data bit on the same edge
        bit_fire = (state_q == StArmed) && x_valid && !abort && !start;
        arm      = start && !abort &&
                   ((state_q != StIdle) || (!cfg_fire && loaded_q));

        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (arm) state_d = StArmed;
            end
            StArmed: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (bit_fire && match && (target_q != '0) && (count_inc == target_q)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (arm) begin
                    state_d = StArmed;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            hist_q      <= '0;
            fill_q      <= '0;
            pat_q       <= '0;
            len_q       <= '0;
            overlap_q   <= 1'b0;
            target_q    <= '0;
            loaded_q    <= 1'b0;
            count_q     <= '0;
            z_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d == StArmed);
            done_q      <= (state_d == StDone);
            cfg_ready_q <= (state_d == StIdle);
            z_q         <= bit_fire && match;

            if (cfg_fire) begin
                pat_q     <= cfg_pattern;
                len_q     <= len_clamped;
                overlap_q <= cfg_overlap;
                target_q  <= cfg_target;
                loaded_q  <= 1'b1;
            end

            if (arm) begin
                hist_q  <= '0;
                fill_q  <= '0;
                count_q <= '0;
            end else if (bit_fire) begin
                hist_q <= hist_new;
                // non-overlapping mode restarts the fill; stale history is masked by fill
                fill_q <= (match && !overlap_q) ? '0 : fill_new;
                if (match) count_q <= count_inc;
            end
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign z           = z_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: inputs change on the falling edge, outputs are
// checked on the following falling edge.
module tb_seq_detect_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int LEN_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic [CNT_W-1:0] cfg_target = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             x = 1'b0;
    logic             x_valid = 1'b0;
    logic             z;
    logic [CNT_W-1:0] match_count;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .x           (x),
        .x_valid     (x_valid),
        .z           (z),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    task automatic do_cfg(input logic [3:0] p, input logic [2:0] l, input logic ov,
                          input logic [7:0] t);
        cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_target = t; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_abort;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({cfg_ready, busy, done, z} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got rdy/busy/done/z=%b want 1000", {cfg_ready, busy, done, z});
        end
        checks++;
        if (match_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", match_count);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_overlap;
        logic [6:0] bits = 7'b1011011;
        logic [6:0] zexp = 7'b0001001;
        do_cfg(4'b1011, 3'd4, 1'b1, 8'd0);
        checks++;
        if ({cfg_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL ovl_idle: got rdy/busy=%b want 10", {cfg_ready, busy});
        end
        pulse_start;
        checks++;
        if ({busy, done, match_count} !== {2'b10, 8'd0}) begin
            errors++;
            $display("FAIL ovl_armed: got busy/done=%b cnt=%0d want 10 cnt=0", {busy, done}, match_count);
        end
        for (int i = 6; i >= 0; i--) begin
            x = bits[i]; x_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (z !== zexp[i]) begin
                errors++;
                $display("FAIL ovl_z bit%0d: got %b want %b", 6 - i, z, zexp[i]);
            end
        end
        x_valid = 1'b0;
        checks++;
        if ({busy, done, match_count} !== {2'b10, 8'd2}) begin
            errors++;
            $display("FAIL ovl_end: got busy/done=%b cnt=%0d want 10 cnt=2", {busy, done}, match_count);
        end
        pulse_abort;
        checks++;
        if ({cfg_ready, busy, done, match_count} !== {3'b100, 8'd2}) begin
            errors++;
            $display("FAIL ovl_abort: got rdy/busy/done=%b cnt=%0d want 100 cnt=2",
                     {cfg_ready, busy, done}, match_count);
        end
    endtask

    task automatic test_no_overlap;
        logic [6:0] bits = 7'b1011011;
        logic [6:0] zexp = 7'b0001000;
        do_cfg(4'b1011, 3'd4, 1'b0, 8'd0);
        pulse_start;
        checks++;
        if (match_count !== 8'd0) begin
            errors++;
            $display("FAIL novl_start_cnt: got %0d want 0", match_count);
        end
        for (int i = 6; i >= 0; i--) begin
            x = bits[i]; x_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (z !== zexp[i]) begin
                errors++;
                $display("FAIL novl_z bit%0d: got %b want %b", 6 - i, z, zexp[i]);
            end
        end
        x_valid = 1'b0;
        checks++;
        if (match_count !== 8'd1) begin
            errors++;
            $display("FAIL novl_cnt: got %0d want 1", match_count);
        end
        pulse_abort;
    endtask

    task automatic test_target;
        logic [6:0] bits = 7'b1011011;
        logic [6:0] zexp = 7'b0001001;
        logic [3:0] more = 4'b1011;
        do_cfg(4'b1011, 3'd4, 1'b1, 8'd2);
        pulse_start;
        for (int i = 6; i >= 0; i--) begin
            x = bits[i]; x_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (z !== zexp[i]) begin
                errors++;
                $display("FAIL tgt_z bit%0d: got %b want %b", 6 - i, z, zexp[i]);
            end
        end
        checks++;
        if ({busy, done, match_count} !== {2'b01, 8'd2}) begin
            errors++;
            $display("FAIL tgt_done: got busy/done=%b cnt=%0d want 01 cnt=2", {busy, done}, match_count);
        end
        for (int i = 3; i >= 0; i--) begin
            x = more[i]; x_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (z !== 1'b0) begin
                errors++;
                $display("FAIL tgt_done_z bit%0d: got %b want 0", 3 - i, z);
            end
        end
        x_valid = 1'b0;
        checks++;
        if ({done, match_count} !== {1'b1, 8'd2}) begin
            errors++;
            $display("FAIL tgt_hold: got done=%b cnt=%0d want 1 cnt=2", done, match_count);
        end
        pulse_start;
        checks++;
        if ({busy, done, match_count} !== {2'b10, 8'd0}) begin
            errors++;
            $display("FAIL tgt_rearm: got busy/done=%b cnt=%0d want 10 cnt=0", {busy, done}, match_count);
        end
        pulse_abort;
    endtask

    task automatic test_gap;
        // x is held at 1 during the gap so sampling an unqualified bit would fake a match
        logic [6:0] xs   = 7'b1011111;
        logic [6:0] vs   = 7'b1100011;
        logic [6:0] zexp = 7'b0000001;
        do_cfg(4'b1011, 3'd4, 1'b1, 8'd0);
        pulse_start;
        for (int i = 6; i >= 0; i--) begin
            x = xs[i]; x_valid = vs[i];
            @(negedge clk);
            checks++;
            if (z !== zexp[i]) begin
                errors++;
                $display("FAIL gap_z cyc%0d: got %b want %b", 6 - i, z, zexp[i]);
            end
        end
        x_valid = 1'b0;
        checks++;
        if (match_count !== 8'd1) begin
            errors++;
            $display("FAIL gap_cnt: got %0d want 1", match_count);
        end
    endtask

    task automatic test_cfg_while_armed;
        logic [7:0] bits = 8'b00001011;
        logic [7:0] zexp = 8'b00000001;
        logic [2:0] pre  = 3'b101;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL armed_rdy: got %b want 0", cfg_ready);
        end
        do_cfg(4'b0000, 3'd4, 1'b1, 8'd0);
        checks++;
        if ({cfg_ready, busy} !== 2'b01) begin
            errors++;
            $display("FAIL armed_cfg: got rdy/busy=%b want 01", {cfg_ready, busy});
        end
        for (int i = 7; i >= 0; i--) begin
            x = bits[i]; x_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (z !== zexp[i]) begin
                errors++;
                $display("FAIL armed_pat_z bit%0d: got %b want %b", 7 - i, z, zexp[i]);
            end
        end
        for (int i = 2; i >= 0; i--) begin
            x = pre[i]; x_valid = 1'b1;
            @(negedge clk);
        end
        x = 1'b1; x_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; x_valid = 1'b0;
        checks++;
        if ({z, cfg_ready, busy, done, match_count} !== {4'b0100, 8'd2}) begin
            errors++;
            $display("FAIL abort_bit: got z/rdy/busy/done=%b cnt=%0d want 0100 cnt=2",
                     {z, cfg_ready, busy, done}, match_count);
        end
        @(negedge clk);
        checks++;
        if (z !== 1'b0) begin
            errors++;
            $display("FAIL abort_z_after: got %b want 0", z);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] bits = 4'b1011;
        logic [3:0] zexp = 4'b0001;
        do_cfg(4'b1011, 3'd4, 1'b1, 8'd0);
        pulse_start;
        for (int i = 3; i >= 0; i--) begin
            x = bits[i]; x_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (z !== zexp[i]) begin
                errors++;
                $display("FAIL rmid_z bit%0d: got %b want %b", 3 - i, z, zexp[i]);
            end
        end
        x_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({cfg_ready, busy, done, z, match_count} !== {4'b1000, 8'd0}) begin
            errors++;
            $display("FAIL rmid_async: got rdy/busy/done/z=%b cnt=%0d want 1000 cnt=0",
                     {cfg_ready, busy, done, z}, match_count);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pulse_start;
        checks++;
        if ({cfg_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL rmid_noconfig_start: got rdy/busy=%b want 10", {cfg_ready, busy});
        end
    endtask

    initial begin
        test_reset;
        test_overlap;
        test_no_overlap;
        test_target;
        test_gap;
        test_cfg_while_armed;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
